branch_predictor_table: RTL and testbench
=========================================

# branch_predictor_table

Parametrised dynamic conditional-branch predictor that replaces the single global prediction bit with a table of saturating counters.
- **Lookup** happens in decode.
- **Resolution** happens in execute, where the predictor updates the selected counter.
- It reports a misprediction so the branching logic can flush and redirect.
- It optionally indexes the table with global history (gshare).

## Interface
Parameters:
- ENTRIES, 16, number of counters; power of two, 2..1024
- CTR_BITS, 2, counter width; 1..4
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden)

Ports:
- Clock  input  1  rising-edge clock
- nReset  input  1  asynchronous active-low reset
- lookupValid  input  1  decode stage presents a conditional branch
- lookupPC  input  32  PC of that branch
- predictTaken  output  1  prediction for lookupPC; 0 when lookupValid=0
- predictIndex  output  IDX_W  table index used for this prediction; travels down the pipeline with the branch
- resolveValid  input  1  execute stage resolves a conditional branch
- resolveIndex  input  IDX_W  predictIndex captured at lookup of this branch
- resolveTaken  input  1  actual outcome (branch condition confirmed)
- resolvePredicted  input  1  prediction made at lookup of this branch
- mispredict  output  1  resolveValid && (resolveTaken != resolvePredicted)
- ghr  output  IDX_W  global history register; all 0 when gshare is compiled out

## Operation
- **Table:**
  - ENTRIES counters, CTR_BITS wide, unsigned.
  - Prediction is the counter MSB.
- **Base index:** lookupPC[IDX_W+1:2]. Bits [1:0] are ignored (word-aligned instructions).
- **Lookup:**
  - Combinational.
  - predictIndex = index function of lookupPC (see Configuration).
  - predictTaken = MSB of table[predictIndex] && lookupValid.
- **Update:** on a rising edge with resolveValid=1:
  - table[resolveIndex] increments if resolveTaken=1 and the counter is below 2^CTR_BITS-1.
  - It decrements if resolveTaken=0 and the counter is above 0.
  - It saturates otherwise; no wrap-around.
- **Misprediction:**
  - mispredict is combinational from the resolve inputs.
  - The table is updated regardless of mispredict.
  - Flush and redirect are owned by the branching logic, not this block.
- **Reset:**
  - Every counter is set to 2^(CTR_BITS-1)-1, i.e. weakly not-taken (2'b01 for CTR_BITS=2; 0 for CTR_BITS=1).
  - ghr is set to 0.
  - Reset mid-operation discards all training immediately (asynchronous).
- **Lookup/resolve to the same index in the same cycle:**
  - Lookup returns the pre-update value; there is no bypass.
  - The update lands at the clock edge.
- **resolveValid=0:** no state changes, mispredict=0.
- **Combinational outputs:** predictTaken and mispredict are purely combinational and not held across reset. Their values during reset are 0, given lookupValid=0 and resolveValid=0.

## Timing
- Lookup latency 0 cycles: predictTaken is valid in the same cycle as lookupPC.
- Update latency 1 edge: a lookup in the cycle after the resolve observes the new counter.
- mispredict latency 0 cycles from resolve inputs.
- Throughput: one lookup and one resolve per cycle.
- No handshake or stall; the caller guarantees one resolve per issued lookup, in order.
- A table read depends only on stored state and lookupPC; there is no path from resolve inputs to predictTaken.

## Configuration
- **Macro:** BRANCH_PREDICTOR_GSHARE_EN.
- **When defined:**
  - predictIndex = lookupPC[IDX_W+1:2] XOR ghr.
  - On every edge with resolveValid=1, ghr <= {ghr[IDX_W-2:0], resolveTaken}. For IDX_W=1, ghr <= resolveTaken.
  - ghr is updated with the actual outcome, not the prediction, so no history repair is needed.
- **When undefined:**
  - predictIndex = lookupPC[IDX_W+1:2].
  - The ghr output is tied to 0 and no history flop exists.

## Test plan
- Reset, then lookupValid=1 with lookupPC=0x40 → predictTaken=0, predictIndex=0x0; all ENTRIES indices read counter 1.
- Resolve index 3 taken twice → counter 1→2→3. A lookup of PC 0x0C then gives predictTaken=1. A third taken resolve leaves the counter at 3 (saturation). Four not-taken resolves end at 0 and do not wrap.
- resolveValid=1, resolveTaken=1, resolvePredicted=0 → mispredict=1 in the same cycle. resolveTaken=resolvePredicted → mispredict=0. resolveValid=0 → mispredict=0 and the table is unchanged.
- Same cycle, lookup PC 0x08 and resolve index 2 taken from counter 1 → predictTaken=0 that cycle, predictTaken=1 the next cycle.
- Assert nReset low mid-run, after index 5 has trained to 3 → table returns to 1 and ghr to 0 without a clock edge; lookup of PC 0x14 gives 0.
- With BRANCH_PREDICTOR_GSHARE_EN, ENTRIES=16: resolve taken, taken, not-taken → ghr=4'b0110. Lookup PC 0x04 → predictIndex=0x7.

Source files
------------

// File: rtl/branch_predictor_table_if.sv
// rtl/branch_predictor_table_if.sv - lookup/resolve bundle between the pipeline and the branch predictor table
interface branch_predictor_table_if #(
    parameter int IDX_W = 4
);
    // Decode-stage lookup
    logic              lookupValid;
    logic [31:0]       lookupPC;
    logic              predictTaken;
    logic [IDX_W-1:0]  predictIndex;

    // Execute-stage resolve
    logic              resolveValid;
    logic [IDX_W-1:0]  resolveIndex;
    logic              resolveTaken;
    logic              resolvePredicted;
    logic              mispredict;

    // Global history (all zero when gshare is not built)
    logic [IDX_W-1:0]  ghr;

    // Pipeline side: presents branches and outcomes, consumes predictions
    modport master (
        output lookupValid,
        output lookupPC,
        output resolveValid,
        output resolveIndex,
        output resolveTaken,
        output resolvePredicted,
        input  predictTaken,
        input  predictIndex,
        input  mispredict,
        input  ghr
    );

    // Predictor side
    modport slave (
        input  lookupValid,
        input  lookupPC,
        input  resolveValid,
        input  resolveIndex,
        input  resolveTaken,
        input  resolvePredicted,
        output predictTaken,
        output predictIndex,
        output mispredict,
        output ghr
    );
endinterface

// File: rtl/branch_predictor_table.sv
// rtl/branch_predictor_table.sv - saturating-counter branch predictor table; gshare indexing via BRANCH_PREDICTOR_GSHARE_EN
module branch_predictor_table #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic                     Clock,
    input  logic                     nReset,
    branch_predictor_table_if.slave  bus
);
    // Index width follows the table size; it is not meant to be overridden.
    localparam int IDX_W = $clog2(ENTRIES);

    // Weakly not-taken: just below the taken threshold (0 for 1-bit counters).
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;

    logic [CTR_BITS-1:0] table_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_d;
    logic [IDX_W-1:0]    base_index;
    logic [IDX_W-1:0]    lookup_index;
    logic [IDX_W-1:0]    ghr_value;
    logic                unused_pc_bits;

    // Word-aligned instructions: bits [1:0] never carry index information.
    assign base_index     = bus.lookupPC[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.lookupPC[31:IDX_W+2], bus.lookupPC[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    // Shift the actual outcome in; history never needs repair after a mispredict.
    always_comb begin
        ghr_d = ghr_q;
        if (bus.resolveValid) begin
            ghr_d = IDX_W'({ghr_q, bus.resolveTaken});
        end
    end

    // Global history register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_value = ghr_q;
`else
    assign ghr_value = '0;
`endif

    // With history absent ghr_value is zero, so the XOR degenerates to the base index.
    assign lookup_index = base_index ^ ghr_value;

    // Lookup reads stored state only; a same-cycle resolve is seen next cycle.
    always_comb begin
        bus.predictIndex = lookup_index;
        bus.predictTaken = bus.lookupValid & table_q[lookup_index][CTR_BITS-1];
    end

    // Misprediction is a pure function of the resolve inputs.
    always_comb begin
        bus.mispredict = bus.resolveValid & (bus.resolveTaken ^ bus.resolvePredicted);
        bus.ghr        = ghr_value;
    end

    // Saturating step of the counter being resolved.
    always_comb begin
        ctr_cur = table_q[bus.resolveIndex];
        ctr_d   = ctr_cur;
        if (bus.resolveTaken) begin
            if (ctr_cur != CTR_MAX) begin
                ctr_d = ctr_cur + 1'b1;
            end
        end else begin
            if (ctr_cur != CTR_MIN) begin
                ctr_d = ctr_cur - 1'b1;
            end
        end
    end

    // Counter table: reset discards all training, resolve trains one entry.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_INIT;
            end
        end else if (bus.resolveValid) begin
            table_q[bus.resolveIndex] <= ctr_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor_table.sv
// tb/tb_branch_predictor_table.sv - randomized self-checking bench for branch_predictor_table
module tb_branch_predictor_table;
    localparam int ENTRIES  = 16;
    localparam int CTR_BITS = 2;
    localparam int IDX_W    = 4;
    localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
    localparam int CTR_MID  = 1 << (CTR_BITS - 1);

    logic Clock;
    logic nReset;
    int   n_checks;
    int   n_errors;

    // Reference state: plain integers
    int model_ctr [ENTRIES];
    int model_ghr;

    branch_predictor_table_if #(.IDX_W(IDX_W)) bp ();

    branch_predictor_table #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bp)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) model_ctr[i] = CTR_MID - 1;
        model_ghr = 0;
    endfunction

    function automatic int model_index(input logic [31:0] pc);
        return ((pc / 4) % ENTRIES) ^ model_ghr;
    endfunction

    task automatic drive(input bit lv, input logic [31:0] pc, input bit rv,
                         input int ridx, input bit rt, input bit rp);
        bp.lookupValid      = lv;
        bp.lookupPC         = pc;
        bp.resolveValid     = rv;
        bp.resolveIndex     = IDX_W'(ridx);
        bp.resolveTaken     = rt;
        bp.resolvePredicted = rp;
        #1;
    endtask

    task automatic check_outputs(input string tag);
        int idx;
        idx = model_index(bp.lookupPC);
        check({tag, ".idx"}, bp.predictIndex, idx);
        check({tag, ".pt"}, bp.predictTaken, (bp.lookupValid && model_ctr[idx] >= CTR_MID) ? 1 : 0);
        check({tag, ".mp"}, bp.mispredict, (bp.resolveValid && bp.resolveTaken != bp.resolvePredicted) ? 1 : 0);
        check({tag, ".ghr"}, bp.ghr, model_ghr);
    endtask

    // Clock edge: the model learns from the resolve the bench is driving.
    task automatic tick();
        @(posedge Clock);
        if (bp.resolveValid) begin
            int r;
            r = int'(bp.resolveIndex);
            if (bp.resolveTaken) model_ctr[r] = (model_ctr[r] < CTR_TOP) ? model_ctr[r] + 1 : CTR_TOP;
            else                 model_ctr[r] = (model_ctr[r] > 0) ? model_ctr[r] - 1 : 0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            model_ghr = ((model_ghr * 2) + (bp.resolveTaken ? 1 : 0)) % ENTRIES;
`endif
        end
        #1;
    endtask

    task automatic step(input string tag, input bit lv, input logic [31:0] pc, input bit rv,
                        input int ridx, input bit rt, input bit rp);
        drive(lv, pc, rv, ridx, rt, rp);
        check_outputs(tag);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        nReset = 1'b0;
        drive(0, 32'h0, 0, 0, 1, 0);
        #10;
        check("rst.pt", bp.predictTaken, 0);
        check("rst.mp", bp.mispredict, 0);
        check("rst.ghr", bp.ghr, 0);
        nReset = 1'b1;
        @(posedge Clock);
        #1;

        step("init40", 1, 32'h40, 0, 0, 0, 0);
        for (int i = 0; i < ENTRIES; i++) step("init", 1, 32'(i * 4), 0, 0, 0, 0);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
        // Same-cycle lookup and resolve on index 2: no bypass.
        drive(1, 32'h08, 1, 2, 1, 0);
        check("haz.now", bp.predictTaken, 0);
        check_outputs("haz0");
        tick();
        drive(1, 32'h08, 0, 0, 0, 0);
        check("haz.next", bp.predictTaken, 1);
        tick();

        // Index 3: train up, saturate, train down, saturate.
        step("t3a", 0, 32'h0, 1, 3, 1, 0);
        step("t3b", 0, 32'h0, 1, 3, 1, 1);
        drive(1, 32'h0C, 1, 3, 1, 1);
        check("sat.pt", bp.predictTaken, 1);
        check("sat.mp", bp.mispredict, 0);
        tick();
        drive(1, 32'h0C, 0, 3, 0, 1);
        check("sattop.pt", bp.predictTaken, 1);
        check("rv0.mp", bp.mispredict, 0);
        tick();
        for (int i = 0; i < 4; i++) step("nt3", 0, 32'h0, 1, 3, 0, 1);
        drive(1, 32'h0C, 0, 0, 0, 0);
        check("satbot.pt", bp.predictTaken, 0);
        tick();
        step("t3c", 0, 32'h0, 1, 3, 1, 0);
        drive(1, 32'h0C, 0, 0, 0, 0);
        check("nowrap.pt", bp.predictTaken, 0);
        tick();
`endif

        // Train index 5 to the top, then reset asynchronously between edges.
        for (int i = 0; i < 3; i++) step("t5", 0, 32'h0, 1, 5, 1, 0);
        drive(1, 32'h14, 0, 0, 0, 0);
        nReset = 1'b0;
        model_reset();
        #1;
        check("arst.pt", bp.predictTaken, 0);
        check("arst.ghr", bp.ghr, 0);
        check_outputs("arst");
        #2;
        nReset = 1'b1;
        @(posedge Clock);
        #1;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
        step("g1", 0, 32'h0, 1, 0, 1, 0);
        step("g2", 0, 32'h0, 1, 0, 1, 0);
        step("g3", 0, 32'h0, 1, 0, 0, 0);
        drive(1, 32'h04, 0, 0, 0, 0);
        check("gsh.ghr", bp.ghr, 4'b0110);
        check("gsh.idx", bp.predictIndex, 4'h7);
        tick();
`endif

        // Random traffic, biased toward collisions between lookup and resolve.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] pc;
            int          ridx;
            pc   = $urandom();
            ridx = ($urandom_range(0, 3) == 0) ? model_index(pc) : int'($urandom_range(0, ENTRIES - 1));
            step("rnd", 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 3) != 0),
                 ridx, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
